// File: rtl/ex_mem_skid_reg.sv
// EX->MEM elastic pipeline register: a main entry presented to MEM plus a one-deep skid entry.
// Latency: one cycle from EX handshake to mem_* outputs, with full throughput while mem_ready stays high.
// Backpressure: ex_ready depends only on state (low in FULL or in reset) and never on mem_ready.
//
// Ports:
//   clock, reset (sync, active-low), flush           - control
//   ex_valid/ex_ready + ex_* fields                   - intake handshake from EX
//   mem_valid/mem_ready + mem_* fields                - main entry handshake to MEM
//   fwd_valid, fwd_rd, fwd_data                       - registered forwarding from the main entry
//   stall_count                                       - saturating count of MEM back-pressure cycles
module ex_mem_skid_reg #(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  // EX side
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [ADDRESS_BITS-1:0] ex_inst_PC,
  input  logic [2:0]              ex_funct3,
  input  logic [4:0]              ex_rd,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  input  logic                    ex_mem_write,
  input  logic [DATA_WIDTH-1:0]   ex_alu_result,
  input  logic [DATA_WIDTH-1:0]   ex_store_data,
  // MEM side
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDRESS_BITS-1:0] mem_inst_PC,
  output logic [2:0]              mem_funct3,
  output logic [4:0]              mem_rd,
  output logic                    mem_reg_write,
  output logic                    mem_mem_read,
  output logic                    mem_mem_write,
  output logic [DATA_WIDTH-1:0]   mem_alu_result,
  output logic [DATA_WIDTH-1:0]   mem_store_data,
  // Forwarding
  output logic                    fwd_valid,
  output logic [4:0]              fwd_rd,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  // Statistics
  output logic [15:0]             stall_count
);

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] pc;
    logic [2:0]              funct3;
    logic [4:0]              rd;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [DATA_WIDTH-1:0]   store_data;
  } entry_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]  state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  logic [15:0] stall_q, stall_d;

  entry_t      ex_entry;
  logic        acc;
  logic        pop;

  // Writes to x0 are architecturally void; drop reg_write at intake so neither
  // the forwarding path nor writeback ever sees them.
  always_comb begin
    ex_entry            = '0;
    ex_entry.pc         = ex_inst_PC;
    ex_entry.funct3     = ex_funct3;
    ex_entry.rd         = ex_rd;
    ex_entry.reg_write  = ex_reg_write & (ex_rd != 5'd0);
    ex_entry.mem_read   = ex_mem_read;
    ex_entry.mem_write  = ex_mem_write;
    ex_entry.alu_result = ex_alu_result;
    ex_entry.store_data = ex_store_data;
  end

  assign ex_ready  = reset & (state_q != ST_FULL);
  assign mem_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign acc       = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          main_d  = ex_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          main_d = ex_entry;
        end else if (acc) begin
          skid_d  = ex_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // No intake here: ex_ready is low, so acc cannot be set.
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins over any handshake; data fields may stay stale but the main
    // entry's side-effect bits are cleared so nothing downstream can act on them.
    if (flush) begin
      state_d          = ST_EMPTY;
      main_d.reg_write = 1'b0;
      main_d.mem_read  = 1'b0;
      main_d.mem_write = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (mem_valid && !mem_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign mem_inst_PC    = main_q.pc;
  assign mem_funct3     = main_q.funct3;
  assign mem_rd         = main_q.rd;
  assign mem_reg_write  = main_q.reg_write;
  assign mem_mem_read   = main_q.mem_read;
  assign mem_mem_write  = main_q.mem_write;
  assign mem_alu_result = main_q.alu_result;
  assign mem_store_data = main_q.store_data;

  // Load results are not known until MEM completes, so only non-load writers forward.
  assign fwd_valid = mem_valid & main_q.reg_write & ~main_q.mem_read;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.alu_result;

  assign stall_count = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [19:0] ex_inst_PC;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [19:0] mem_inst_PC;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_store_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [15:0] stall_count;

  ex_mem_skid_reg #(.CORE(0), .ADDRESS_BITS(20), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst_PC(ex_inst_PC),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_inst_PC(mem_inst_PC),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One row = inputs held for one cycle, then expected outputs after that edge.
  typedef struct {
    logic        exv;
    logic [19:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [31:0] alu;
    logic        mrdy;
    logic        fl;
    logic        e_rdy;
    logic        e_mv;
    logic [19:0] e_pc;
    logic [4:0]  e_rd;
    logic        e_mrw;
    logic        e_fv;
    logic [31:0] e_fd;
    logic [15:0] e_st;
  } vec_t;

  function automatic vec_t mk(logic exv, logic [19:0] pc, logic [4:0] rd, logic rw, logic mr,
                              logic [31:0] alu, logic mrdy, logic fl,
                              logic e_rdy, logic e_mv, logic [19:0] e_pc, logic [4:0] e_rd,
                              logic e_mrw, logic e_fv, logic [31:0] e_fd, logic [15:0] e_st);
    vec_t v;
    v.exv = exv; v.pc = pc; v.rd = rd; v.rw = rw; v.mr = mr; v.alu = alu;
    v.mrdy = mrdy; v.fl = fl; v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_pc = e_pc;
    v.e_rd = e_rd; v.e_mrw = e_mrw; v.e_fv = e_fv; v.e_fd = e_fd; v.e_st = e_st;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic drive_ex(input logic exv, input logic [19:0] pc, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic [31:0] alu);
    ex_valid      = exv;
    ex_inst_PC    = pc;
    ex_funct3     = pc[4:2];
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = 1'b0;
    ex_alu_result = alu;
    ex_store_data = ~alu;
  endtask

  initial begin
    //        exv  pc      rd  rw mr alu            mrdy fl | rdy mv pc      rd  mrw fv fd             st
    // streaming at full rate
    vecs[0]  = mk(1, 'h100, 1,  1, 0, 'h11,         1, 0,   1, 1, 'h100, 1,  1, 1, 'h11,         0);
    vecs[1]  = mk(1, 'h104, 2,  1, 0, 'h22,         1, 0,   1, 1, 'h104, 2,  1, 1, 'h22,         0);
    vecs[2]  = mk(1, 'h108, 3,  1, 0, 'h33,         1, 0,   1, 1, 'h108, 3,  1, 1, 'h33,         0);
    vecs[3]  = mk(1, 'h10C, 4,  1, 0, 'h44,         1, 0,   1, 1, 'h10C, 4,  1, 1, 'h44,         0);
    vecs[4]  = mk(0, 'h0,   0,  0, 0, 'h0,          1, 0,   1, 0, 'h0,   0,  0, 0, 'h0,          0);
    // back-pressure fills the skid, then drains in order
    vecs[5]  = mk(1, 'h200, 6,  1, 0, 'h200,        0, 0,   1, 1, 'h200, 6,  1, 1, 'h200,        0);
    vecs[6]  = mk(1, 'h204, 7,  1, 0, 'h204,        0, 0,   0, 1, 'h200, 6,  1, 1, 'h200,        1);
    vecs[7]  = mk(1, 'h208, 8,  1, 0, 'h208,        0, 0,   0, 1, 'h200, 6,  1, 1, 'h200,        2);
    vecs[8]  = mk(1, 'h208, 8,  1, 0, 'h208,        1, 0,   1, 1, 'h204, 7,  1, 1, 'h204,        2);
    vecs[9]  = mk(1, 'h208, 8,  1, 0, 'h208,        1, 0,   1, 1, 'h208, 8,  1, 1, 'h208,        2);
    vecs[10] = mk(0, 'h0,   0,  0, 0, 'h0,          1, 0,   1, 0, 'h0,   0,  0, 0, 'h0,          2);
    // forwarding qualifiers
    vecs[11] = mk(1, 'h300, 5,  1, 0, 'hDEADBEEF,   1, 0,   1, 1, 'h300, 5,  1, 1, 'hDEADBEEF,   2);
    vecs[12] = mk(1, 'h304, 5,  1, 1, 'h1000,       1, 0,   1, 1, 'h304, 5,  1, 0, 'h1000,       2);
    vecs[13] = mk(1, 'h308, 0,  1, 0, 'h55,         1, 0,   1, 1, 'h308, 0,  0, 0, 'h55,         2);
    vecs[14] = mk(0, 'h0,   0,  0, 0, 'h0,          1, 0,   1, 0, 'h0,   0,  0, 0, 'h0,          2);
    // rd = 0 landing in the skid entry
    vecs[15] = mk(1, 'h400, 9,  1, 0, 'h9,          0, 0,   1, 1, 'h400, 9,  1, 1, 'h9,          2);
    vecs[16] = mk(1, 'h404, 0,  1, 0, 'h4,          0, 0,   0, 1, 'h400, 9,  1, 1, 'h9,          3);
    vecs[17] = mk(0, 'h0,   0,  0, 0, 'h0,          1, 0,   1, 1, 'h404, 0,  0, 0, 'h4,          3);
    // fill to FULL, then flush with intake and pop requested on the same edge
    vecs[18] = mk(1, 'h410, 12, 1, 0, 'h410,        1, 0,   1, 1, 'h410, 12, 1, 1, 'h410,        3);
    vecs[19] = mk(1, 'h500, 10, 1, 0, 'h500,        0, 0,   0, 1, 'h410, 12, 1, 1, 'h410,        4);
    vecs[20] = mk(1, 'h504, 11, 1, 0, 'h504,        1, 1,   1, 0, 'h0,   0,  0, 0, 'h0,          4);
    vecs[21] = mk(0, 'h0,   0,  0, 0, 'h0,          1, 0,   1, 0, 'h0,   0,  0, 0, 'h0,          4);

    // Reset held two edges with EX presenting an instruction
    reset = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b1;
    drive_ex(1, 'h0F0, 3, 1, 0, 'h77);
    repeat (2) @(posedge clock);
    #1;
    chk("reset mem_valid", {31'd0, mem_valid}, 0);
    chk("reset stall_count", {16'd0, stall_count}, 0);
    chk("reset ex_ready", {31'd0, ex_ready}, 0);
    chk("reset fwd_valid", {31'd0, fwd_valid}, 0);
    chk("reset mem_reg_write", {31'd0, mem_reg_write}, 0);
    chk("reset mem_alu_result", mem_alu_result, 0);
    reset = 1'b1;
    drive_ex(0, 'h0, 0, 0, 0, 'h0);
    #1;
    chk("release ex_ready", {31'd0, ex_ready}, 1);

    for (int i = 0; i < NV; i++) begin
      drive_ex(vecs[i].exv, vecs[i].pc, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].alu);
      mem_ready = vecs[i].mrdy;
      flush     = vecs[i].fl;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d ex_ready", i), {31'd0, ex_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d mem_valid", i), {31'd0, mem_valid}, {31'd0, vecs[i].e_mv});
      chk($sformatf("v%0d fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vecs[i].e_fv});
      chk($sformatf("v%0d stall_count", i), {16'd0, stall_count}, {16'd0, vecs[i].e_st});
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d mem_inst_PC", i), {12'd0, mem_inst_PC}, {12'd0, vecs[i].e_pc});
        chk($sformatf("v%0d mem_funct3", i), {29'd0, mem_funct3}, {29'd0, vecs[i].e_pc[4:2]});
        chk($sformatf("v%0d mem_rd", i), {27'd0, mem_rd}, {27'd0, vecs[i].e_rd});
        chk($sformatf("v%0d mem_reg_write", i), {31'd0, mem_reg_write}, {31'd0, vecs[i].e_mrw});
        chk($sformatf("v%0d fwd_rd", i), {27'd0, fwd_rd}, {27'd0, vecs[i].e_rd});
        chk($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].e_fd);
        chk($sformatf("v%0d mem_store_data", i), mem_store_data, ~vecs[i].e_fd);
      end
      if (vecs[i].fl) begin
        chk($sformatf("v%0d flush reg_write", i), {31'd0, mem_reg_write}, 0);
        chk($sformatf("v%0d flush mem_read", i), {31'd0, mem_mem_read}, 0);
        chk($sformatf("v%0d flush mem_write", i), {31'd0, mem_mem_write}, 0);
      end
    end

    // Saturation: park one entry in main with MEM stalled (counter starts at 4)
    flush = 1'b0;
    mem_ready = 1'b0;
    drive_ex(1, 'h600, 1, 1, 0, 'h600);
    @(posedge clock);
    #1;
    drive_ex(0, 'h0, 0, 0, 0, 'h0);
    chk("sat start", {16'd0, stall_count}, 4);
    repeat (65530) @(posedge clock);
    #1;
    chk("sat near", {16'd0, stall_count}, 'hFFFE);
    @(posedge clock);
    #1;
    chk("sat reached", {16'd0, stall_count}, 'hFFFF);
    repeat (100) @(posedge clock);
    #1;
    chk("sat hold", {16'd0, stall_count}, 'hFFFF);
    chk("sat mem_valid", {31'd0, mem_valid}, 1);
    chk("sat mem_inst_PC", {12'd0, mem_inst_PC}, 'h600);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush keeps stall", {16'd0, stall_count}, 'hFFFF);
    chk("flush mem_valid", {31'd0, mem_valid}, 0);

    // Reset mid-operation overrides intake and pop
    drive_ex(1, 'h700, 2, 1, 0, 'h700);
    @(posedge clock);
    #1;
    chk("pre-reset mem_valid", {31'd0, mem_valid}, 1);
    reset = 1'b0;
    mem_ready = 1'b1;
    drive_ex(1, 'h704, 3, 1, 0, 'h704);
    @(posedge clock);
    #1;
    chk("mid reset mem_valid", {31'd0, mem_valid}, 0);
    chk("mid reset stall", {16'd0, stall_count}, 0);
    chk("mid reset alu", mem_alu_result, 0);
    chk("mid reset ex_ready", {31'd0, ex_ready}, 0);
    reset = 1'b1;
    drive_ex(0, 'h0, 0, 0, 0, 'h0);
    @(posedge clock);
    #1;
    chk("post reset mem_valid", {31'd0, mem_valid}, 0);
    chk("post reset ex_ready", {31'd0, ex_ready}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
